// File: rtl/debounce_multi.sv
// Multi-channel switch debouncer. Each channel synchronises its raw input,
// then requires the synchronised level to differ from the debounced output
// for `threshold` tick-qualified cycles before the output follows it.
// Rise/fall strobes are registered with the output so they coincide with
// the first cycle of the new level.

module debounce_lane #(
    parameter int   CNT_W       = 16,
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic [CNT_W-1:0] threshold,
    input  logic             sw_in,
    output logic             sw_out,
    output logic             rise,
    output logic             fall,
    output logic             chg_d
);
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   out_q, out_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   sync, mis;

    assign sync = sync_q[SYNC_STAGES-1];
    assign mis  = sync ^ out_q;

    // Plain flop chain for metastability settling; no logic between stages.
    always_comb sync_d = {sync_q[SYNC_STAGES-2:0], sw_in};

    // Stability counter: clear on agreement, flip once the count is reached
    // (tick not needed for the flip), otherwise count on tick. The counter
    // stops at threshold, so it can never wrap.
    always_comb begin
        cnt_d  = cnt_q;
        out_d  = out_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (!mis) begin
            cnt_d = '0;
        end else if (cnt_q >= threshold) begin
            out_d  = sync;
            cnt_d  = '0;
            rise_d = sync;
            fall_d = ~sync;
        end else if (tick) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // State registers, asynchronously forced to the reset level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            cnt_q  <= '0;
            out_q  <= RESET_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            out_q  <= out_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign sw_out = out_q;
    assign rise   = rise_q;
    assign fall   = fall_q;
    assign chg_d  = rise_d | fall_d;
endmodule

module debounce_multi #(
    parameter int   CHANNELS    = 4,
    parameter int   CNT_W       = 16,
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tick,
    input  logic [CNT_W-1:0]    threshold,
    input  logic [CHANNELS-1:0] switch_in,
    output logic [CHANNELS-1:0] switch_out,
    output logic [CHANNELS-1:0] rise_pulse,
    output logic [CHANNELS-1:0] fall_pulse,
    output logic                any_change
);
    logic [CHANNELS-1:0] chg_d;
    logic                any_change_q, any_change_d;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
        debounce_lane #(
            .CNT_W      (CNT_W),
            .SYNC_STAGES(SYNC_STAGES),
            .RESET_VAL  (RESET_VAL)
        ) u_lane (
            .clk      (clk),
            .reset    (reset),
            .tick     (tick),
            .threshold(threshold),
            .sw_in    (switch_in[g]),
            .sw_out   (switch_out[g]),
            .rise     (rise_pulse[g]),
            .fall     (fall_pulse[g]),
            .chg_d    (chg_d[g])
        );
    end

    // Summary strobe built from next-state pulses so it lines up with them.
    always_comb any_change_d = |chg_d;

    // Summary strobe register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) any_change_q <= 1'b0;
        else       any_change_q <= any_change_d;
    end

    assign any_change = any_change_q;
endmodule

// File: tb/tb_debounce_multi.sv
// Randomised and directed bench for debounce_multi against a cycle-level
// reference model derived from the debouncing rules.
`timescale 1ns/1ps
module tb_debounce_multi;
    localparam int   CH = 4;
    localparam int   CW = 16;
    localparam int   SS = 2;
    localparam logic RV = 1'b0;

    logic          clk = 1'b0;
    logic          reset;
    logic          tick;
    logic [CW-1:0] threshold;
    logic [CH-1:0] switch_in, switch_out, rise_pulse, fall_pulse;
    logic          any_change;

    always #5 clk = ~clk;

    debounce_multi #(.CHANNELS(CH), .CNT_W(CW), .SYNC_STAGES(SS), .RESET_VAL(RV)) dut (
        .clk(clk), .reset(reset), .tick(tick), .threshold(threshold),
        .switch_in(switch_in), .switch_out(switch_out), .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse), .any_change(any_change)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: input history, run lengths, debounced level, strobes
    logic [CH-1:0] hist [SS];
    int            run_m [CH];
    logic [CH-1:0] out_m, rise_m, fall_m;
    logic          any_m;
    int            tmode = 0;
    int            cnum  = 0;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < SS; k++) hist[k] = {CH{RV}};
        for (int c = 0; c < CH; c++) run_m[c] = 0;
        out_m  = {CH{RV}};
        rise_m = '0;
        fall_m = '0;
        any_m  = 1'b0;
    endtask

    // One clock edge: the debouncer sees the input from SS edges ago.
    task automatic model_edge();
        logic [CH-1:0] s;
        s      = hist[SS-1];
        rise_m = '0;
        fall_m = '0;
        for (int c = 0; c < CH; c++) begin
            if (s[c] == out_m[c]) run_m[c] = 0;
            else if (run_m[c] >= int'(threshold)) begin
                out_m[c] = s[c];
                run_m[c] = 0;
                if (s[c]) rise_m[c] = 1'b1; else fall_m[c] = 1'b1;
            end else if (tick) run_m[c] = run_m[c] + 1;
        end
        any_m = (rise_m != 0) || (fall_m != 0);
        for (int k = SS-1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = switch_in;
    endtask

    task automatic chk_all(string tag);
        chk({tag, ".out"},  32'(switch_out), 32'(out_m));
        chk({tag, ".rise"}, 32'(rise_pulse), 32'(rise_m));
        chk({tag, ".fall"}, 32'(fall_pulse), 32'(fall_m));
        chk({tag, ".any"},  32'(any_change), 32'(any_m));
    endtask

    // Advance one clock, check on the falling edge, then set next tick.
    task automatic cyc(string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk_all(tag);
        cnum++;
        case (tmode)
            0:       tick = 1'b1;
            1:       tick = (cnum % 4 == 0);
            default: tick = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic run(string tag, int n);
        for (int i = 0; i < n; i++) cyc(tag);
    endtask

    // Edges (counting the first one after the input change) until channel ch strobes.
    task automatic lat(string tag, int ch, int exp, int bound);
        int  n;
        bit  hit;
        n   = 0;
        hit = 0;
        while (!hit && n < bound) begin
            cyc(tag);
            n++;
            if (rise_pulse[ch] | fall_pulse[ch]) hit = 1;
        end
        chk({tag, ".lat"}, hit ? 32'(n) : 32'hFFFF_FFFF, 32'(exp));
    endtask

    initial begin
        int anys;
        reset     = 1'b1;
        tick      = 1'b1;
        threshold = 16'd3;
        switch_in = '0;
        model_reset();

        // reset and idle
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all("rst");
        reset = 1'b0;
        run("idle", 20);

        // clean press on ch0, threshold 3
        switch_in[0] = 1'b1;
        lat("press", 0, SS + 3 + 1, 50);
        chk("press.rise0", 32'(rise_pulse[0]), 32'd1);
        chk("press.any", 32'(any_change), 32'd1);
        run("press", 10);

        // bounce on ch1, threshold 5
        threshold = 16'd5;
        for (int b = 0; b < 4; b++) begin
            switch_in[1] = 1'b1; cyc("bounce");
            switch_in[1] = 1'b0; cyc("bounce");
        end
        chk("bounce.out1", 32'(switch_out[1]), 32'd0);
        switch_in[1] = 1'b1;
        lat("bounce", 1, SS + 5 + 1, 50);
        run("bounce", 10);
        switch_in[1] = 1'b0;
        lat("release", 1, SS + 5 + 1, 50);
        chk("release.fall1", 32'(fall_pulse[1]), 32'd1);
        run("release", 10);

        // prescaled counting on ch2, threshold 2
        threshold = 16'd2;
        tmode = 1;
        switch_in[2] = 1'b1;
        run("presc.drop", 4);
        switch_in[2] = 1'b0;
        run("presc.drop", 20);
        chk("presc.drop.out2", 32'(switch_out[2]), 32'd0);
        switch_in[2] = 1'b1;
        run("presc", 30);
        chk("presc.out2", 32'(switch_out[2]), 32'd1);
        switch_in[2] = 1'b0;
        run("presc", 30);
        tmode = 0;
        tick  = 1'b1;

        // threshold 0
        threshold = 16'd0;
        switch_in[0] = 1'b0;
        lat("thr0", 0, SS + 0 + 1, 20);
        run("thr0", 5);

        // lower threshold mid-count on ch3
        threshold = 16'd100;
        switch_in[3] = 1'b1;
        run("lower", SS + 50);
        chk("lower.out3", 32'(switch_out[3]), 32'd0);
        threshold = 16'd10;
        cyc("lower");
        chk("lower.rise3", 32'(rise_pulse[3]), 32'd1);
        switch_in[3] = 1'b0;
        run("lower", 20);

        // simultaneous flips on all channels
        threshold = 16'd3;
        switch_in = '0;
        run("simul", 20);
        switch_in = '1;
        lat("simul", 0, SS + 3 + 1, 50);
        chk("simul.rise", 32'(rise_pulse), 32'hF);
        chk("simul.any", 32'(any_change), 32'd1);
        anys = 0;
        for (int i = 0; i < 10; i++) begin
            cyc("simul");
            anys += int'(any_change);
        end
        chk("simul.any_once", 32'(anys), 32'd0);

        // asynchronous reset mid-count
        switch_in = '0;
        run("midrst", 4);
        #2 reset = 1'b1;
        #1;
        chk("midrst.out", 32'(switch_out), 32'(RV));
        chk("midrst.pulses", 32'({rise_pulse, fall_pulse, any_change}), 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        run("postrst", 20);

        // saturated threshold
        threshold = 16'hFFFF;
        switch_in[0] = 1'b1;
        lat("thrmax", 0, SS + 65535 + 1, 70000);
        switch_in[0] = 1'b0;
        threshold = 16'd3;
        run("thrmax", 20);

        // randomised traffic
        tmode = 2;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) threshold = 16'($urandom_range(0, 4));
            for (int c = 0; c < CH; c++)
                if ($urandom_range(0, 7) == 0) switch_in[c] = ~switch_in[c];
            cyc("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
